// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
//   Handshake bundle between the ALU, the result stage and writeback.
//   Upstream side : in_valid/in_ready plus the ALU payload
//                   (result, Z/C/N/V flags, rd, wen, setf).
//   Downstream    : out_valid/out_ready plus the buffered payload
//                   (result, rd, wen).
//   modport slave  - the result stage itself.
//   modport master - the environment (ALU on the input side, writeback on
//                    the output side).
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_fZ;
    logic              in_fC;
    logic              in_fN;
    logic              in_fV;
    logic [REG_AW-1:0] in_rd;
    logic              in_wen;
    logic              in_setf;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_AW-1:0] out_rd;
    logic              out_wen;

    modport slave (
        input  in_valid, in_result, in_fZ, in_fC, in_fN, in_fV,
               in_rd, in_wen, in_setf, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wen
    );

    modport master (
        output in_valid, in_result, in_fZ, in_fC, in_fN, in_fV,
               in_rd, in_wen, in_setf, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wen
    );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registers the ALU result behind a 2-entry skid buffer (main + skid) so
//   writeback back-pressure never loses a result, owns the NZCV status
//   register, and evaluates the branch condition from that register.
//
//   Ports:
//     clk       - rising-edge clock
//     rst_n     - asynchronous active-low reset
//     flush     - synchronous flush, discards buffered entries and any
//                 accept in the same cycle
//     bus       - alu_result_stage_if.slave, input and output handshakes
//     flags     - status register {N,Z,C,V}
//     cond      - branch condition selector
//     cond_true - selected condition holds for the current flags
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_result_stage_if.slave bus,
    output logic [3:0]        flags,
    input  logic [2:0]        cond,
    output logic              cond_true
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_inReady;
    logic              r_outValid;
    logic [DATA_W-1:0] r_mainResult;
    logic [REG_AW-1:0] r_mainRd;
    logic              r_mainWen;
    logic [DATA_W-1:0] r_skidResult;
    logic [REG_AW-1:0] r_skidRd;
    logic              r_skidWen;
    logic [3:0]        r_flags;

    logic w_accept;
    logic w_pop;
    logic w_condTrue;

    assign w_accept = bus.in_valid & r_inReady;
    assign w_pop    = r_outValid & bus.out_ready;

    // in_ready and out_valid are kept as their own flops, updated together
    // with the state, so neither has any combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_inReady    <= 1'b1;
            r_outValid   <= 1'b0;
            r_mainResult <= '0;
            r_mainRd     <= '0;
            r_mainWen    <= 1'b0;
            r_skidResult <= '0;
            r_skidRd     <= '0;
            r_skidWen    <= 1'b0;
            r_flags      <= 4'b0000;
        end else if (flush) begin
            // Same-cycle accept is dropped entirely, including its flags.
            r_state    <= EMPTY;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            // Flags follow program order, so they update on accept, not pop.
            if (w_accept && bus.in_setf) begin
                r_flags <= {bus.in_fN, bus.in_fZ, bus.in_fC, bus.in_fV};
            end

            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_mainResult <= bus.in_result;
                        r_mainRd     <= bus.in_rd;
                        r_mainWen    <= bus.in_wen;
                        r_state      <= ONE;
                        r_outValid   <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_mainResult <= bus.in_result;
                        r_mainRd     <= bus.in_rd;
                        r_mainWen    <= bus.in_wen;
                    end else if (w_accept) begin
                        // Main is still waiting; the newer entry goes to skid.
                        r_skidResult <= bus.in_result;
                        r_skidRd     <= bus.in_rd;
                        r_skidWen    <= bus.in_wen;
                        r_state      <= FULL;
                        r_inReady    <= 1'b0;
                    end else if (w_pop) begin
                        r_state    <= EMPTY;
                        r_outValid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_mainResult <= r_skidResult;
                        r_mainRd     <= r_skidRd;
                        r_mainWen    <= r_skidWen;
                        r_state      <= ONE;
                        r_inReady    <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    // Branch condition decode; r_flags is {N,Z,C,V}.
    always_comb begin
        w_condTrue = 1'b1;
        case (cond)
            3'b000:  w_condTrue = 1'b1;
            3'b001:  w_condTrue = r_flags[2];
            3'b010:  w_condTrue = ~r_flags[2];
            3'b011:  w_condTrue = r_flags[1];
            3'b100:  w_condTrue = ~r_flags[1];
            3'b101:  w_condTrue = r_flags[3];
            3'b110:  w_condTrue = (r_flags[3] == r_flags[0]);
            3'b111:  w_condTrue = (r_flags[3] != r_flags[0]);
            default: w_condTrue = 1'b1;
        endcase
    end

    assign bus.in_ready   = r_inReady;
    assign bus.out_valid  = r_outValid;
    assign bus.out_result = r_mainResult;
    assign bus.out_rd     = r_mainRd;
    assign bus.out_wen    = r_mainWen;
    assign flags          = r_flags;
    assign cond_true      = w_condTrue;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//   Directed bench for alu_result_stage. Accepted entries are pushed to a
//   scoreboard queue and compared in order as writeback pops them; flags and
//   branch conditions are checked against known constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_result_stage;

    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  rd;
        logic        wen;
    } entry_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [3:0] flags;
    logic [2:0] cond;
    logic       cond_true;

    int nTests;
    int nFail;
    entry_t sbQ[$];

    alu_result_stage_if #(.DATA_W(16), .REG_AW(3)) bus ();

    alu_result_stage #(.DATA_W(16), .REG_AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

    // 20 ns clock, rising edges at 10, 30, 50 ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nTests++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCond(input logic [2:0] sel, input logic expected, input string tag);
        cond = sel;
        #1;
        checkOutput(tag, {31'd0, cond_true}, {31'd0, expected});
    endtask

    // Drive the upstream payload; takes effect for the current cycle.
    task automatic applyStimulus(input logic valid, input logic [15:0] result,
                                 input logic [2:0] rd, input logic wen, input logic setf,
                                 input logic fN, input logic fZ, input logic fC, input logic fV);
        bus.in_valid  = valid;
        bus.in_result = result;
        bus.in_rd     = rd;
        bus.in_wen    = wen;
        bus.in_setf   = setf;
        bus.in_fN     = fN;
        bus.in_fZ     = fZ;
        bus.in_fC     = fC;
        bus.in_fV     = fV;
    endtask

    // Mid-cycle: score any pop, record any accept, then advance one edge.
    task automatic cycle();
        entry_t e;
        #5;
        if (bus.out_valid && bus.out_ready) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_pop", {16'd0, bus.out_result}, 32'hFFFF_FFFF);
            end else begin
                e = sbQ.pop_front();
                checkOutput("pop_result", {16'd0, bus.out_result}, {16'd0, e.result});
                checkOutput("pop_rd", {29'd0, bus.out_rd}, {29'd0, e.rd});
                checkOutput("pop_wen", {31'd0, bus.out_wen}, {31'd0, e.wen});
            end
        end
        if (flush) begin
            sbQ.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            e.result = bus.in_result;
            e.rd     = bus.in_rd;
            e.wen    = bus.in_wen;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        rst_n  = 1'b1;
        flush  = 1'b0;
        cond   = 3'b000;
        bus.out_ready = 1'b0;
        idle();

        // ---------------- power-on reset ----------------
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_flags", {28'd0, flags}, 32'd0);
        checkOutput("rst_out_result", {16'd0, bus.out_result}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- streaming ----------------
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 16'(i), 3'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
            cycle();
            checkOutput("stream_out_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("stream_out_result", {16'd0, bus.out_result}, i);
        end
        idle();
        cycle();
        checkOutput("stream_drained", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("stream_sb_empty", sbQ.size(), 32'd0);

        // ---------------- back-pressure ----------------
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'hAAAA, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 16'h5555, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        checkOutput("bp_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("bp_full_valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("bp_hold_result", {16'd0, bus.out_result}, 32'hAAAA);
        cycle();
        checkOutput("bp_hold_result2", {16'd0, bus.out_result}, 32'hAAAA);
        checkOutput("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        cycle();
        checkOutput("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("bp_second_result", {16'd0, bus.out_result}, 32'h5555);
        cycle();
        checkOutput("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // ---------------- flags and conditions ----------------
        applyStimulus(1'b1, 16'h0042, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        idle();
        checkOutput("flags_1010", {28'd0, flags}, 32'b1010);
        checkCond(3'b110, 1'b0, "cond_GE_1010");
        checkCond(3'b111, 1'b1, "cond_LT_1010");
        checkCond(3'b011, 1'b1, "cond_CS_1010");
        checkCond(3'b010, 1'b1, "cond_NE_1010");
        checkCond(3'b001, 1'b0, "cond_EQ_1010");
        applyStimulus(1'b1, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        idle();
        checkOutput("flags_nosetf", {28'd0, flags}, 32'b1010);
        cycle();

        // ---------------- signed overflow ----------------
        applyStimulus(1'b1, 16'h8000, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        idle();
        checkOutput("flags_1001", {28'd0, flags}, 32'b1001);
        checkCond(3'b110, 1'b1, "cond_GE_1001");
        checkCond(3'b101, 1'b1, "cond_MI_1001");
        checkCond(3'b100, 1'b1, "cond_CC_1001");
        cycle();

        // ---------------- flush ----------------
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'h4321, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        checkOutput("flush_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        flush = 1'b1;
        applyStimulus(1'b1, 16'h1234, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        flush = 1'b0;
        idle();
        checkOutput("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("flush_flags", {28'd0, flags}, 32'b1001);
        checkOutput("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("flush_no_ghost", {31'd0, bus.out_valid}, 32'd0);
        end

        // ---------------- async reset while FULL ----------------
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'h1111, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b1, 16'h2222, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        checkOutput("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("pre_rst_flags", {28'd0, flags}, 32'b1111);
        #3 rst_n = 1'b0;
        #1;
        sbQ.delete();
        checkOutput("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("arst_flags", {28'd0, flags}, 32'd0);
        checkOutput("arst_out_result", {16'd0, bus.out_result}, 32'd0);
        checkCond(3'b000, 1'b1, "arst_cond_AL");
        checkCond(3'b001, 1'b0, "arst_cond_EQ");
        @(posedge clk);
        #1;
        checkOutput("arst_held_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU: registers the ALU result, destination register and Z/C/N/V flags, and hands them to writeback over a valid/ready handshake.
- Contains a 2-entry skid buffer so writeback back-pressure never drops an ALU result.
- Owns the architectural NZCV status register and a combinational branch-condition evaluator that feeds fetch/branch logic.

Parameters:
DATA_W, 16, result width (matches ALU operand width)
REG_AW, 3, destination register index width (8 registers)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush, discards buffered entries
in_valid  input  1  upstream presents an ALU result this cycle
in_ready  output  1  stage can accept an entry this cycle
in_result  input  DATA_W  ALU result o
in_fZ  input  1  ALU zero flag
in_fC  input  1  ALU carry flag
in_fN  input  1  ALU negative flag
in_fV  input  1  ALU overflow flag
in_rd  input  REG_AW  destination register index
in_wen  input  1  entry writes the register file
in_setf  input  1  entry updates the status register
out_valid  output  1  entry available to writeback
out_ready  input  1  writeback consumes the entry this cycle
out_result  output  DATA_W  buffered result
out_rd  output  REG_AW  buffered destination index
out_wen  output  1  buffered write enable
flags  output  4  status register {N,Z,C,V}
cond  input  3  branch condition selector
cond_true  output  1  selected condition holds for current flags

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; out_valid=0; in_ready=1; flags=4'b0000; out_result=0, out_rd=0, out_wen=0; skid contents=0. Clock edges are ignored while rst_n is low. Reset mid-transfer discards every buffered entry.
- Handshake:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready is a pure register output, equal to (state != FULL). It has no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - Input payload is sampled only on accept. Output payload is stable while out_valid & !out_ready.
- States:
  - EMPTY: accept -> ONE, main <= input.
  - ONE:
    - accept & pop -> ONE, main <= input.
    - accept & !pop -> FULL, skid <= input.
    - pop & !accept -> EMPTY.
    - Otherwise hold.
  - FULL (in_ready=0): pop -> ONE, main <= skid. Otherwise hold.
- Latency: accept in cycle N gives out_valid in cycle N+1 (when EMPTY or when ONE with a simultaneous pop). Throughput is one entry per cycle with out_ready held high.
- Ordering: strictly FIFO; skid is always older-after-main.
- Payload registers hold their last value when not loaded. out_* are don't-care when out_valid=0, but they are deterministic as specified.
- Status register:
  - On accept with in_setf=1: flags <= {in_fN, in_fZ, in_fC, in_fV}. The new value is visible the next cycle.
  - The status register is updated at accept time, not at pop, so flags follow program order independent of back-pressure.
  - Accept with in_setf=0 leaves flags unchanged.
- flush:
  - flush=1 at a clock edge forces state EMPTY. Any accept in that same cycle is discarded: no buffer load and no flag update.
  - A pop in that cycle is still considered consumed by writeback.
  - Flags written by earlier accepts are retained.
  - in_ready returns to 1 the cycle after flush.
- cond_true (combinational, from flags register only):
  - 000 AL = 1
  - 001 EQ = Z
  - 010 NE = !Z
  - 011 CS = C
  - 100 CC = !C
  - 101 MI = N
  - 110 GE = (N == V)
  - 111 LT = (N != V)
- Widths: no arithmetic in this block; all fields pass through unmodified at their full width.

Test Plan:
- Reset: rst_n low asynchronously mid-cycle with state FULL -> immediately out_valid=0, in_ready=1, flags=0000, out_result=0x0000; cond=000 gives cond_true=1, cond=001 gives cond_true=0.
- Streaming: out_ready=1, accept results 0x0001, 0x0002, 0x0003 on consecutive cycles -> out_result 0x0001, 0x0002, 0x0003 on the following cycles with out_valid=1 and in_ready constantly 1.
- Back-pressure:
  - Stimulus: out_ready=0, accept 0xAAAA then 0x5555.
  - Required: state FULL, in_ready=0, out_result=0xAAAA held stable.
  - Then raise out_ready for 2 cycles -> outputs 0xAAAA then 0x5555, out_valid=0 after, in_ready=1 one cycle after first pop.
- Flags and conditions:
  - Accept with setf=1, flags N=1, Z=0, C=1, V=0 -> next cycle flags=1010; GE gives 0, LT gives 1, CS gives 1, NE gives 1.
  - Then accept with setf=0 and Z=1 -> flags remain 1010.
- Signed overflow case: accept 0x7FFF+0x0001 ALU outputs (o=0x8000, N=1, Z=0, C=0, V=1) with setf=1 -> flags=1001; GE gives 1, MI gives 1.
- Flush: state ONE, in the same cycle flush=1 and accept 0x1234 with setf=1, Z=1 -> next cycle out_valid=0, flags unchanged, in_ready=1; 0x1234 never appears on out_result.
